// File: rtl/ins_bundle_queue.sv
// Bundle decoupling FIFO between predecode and rename: first-word-fall-through,
// registered-state outputs only, flush/reset empty the queue in one edge.
module ins_bundle_queue #(
  parameter int DEPTH    = 4,
  parameter int BUNDLE_W = 256
) (
  input  logic                       cpu_clock_i,
  input  logic                       reset_i,
  input  logic                       flush_i,
  input  logic [BUNDLE_W-1:0]        bundle_i,
  input  logic                       bundle_vld_i,
  output logic                       busy_o,
  output logic [BUNDLE_W-1:0]        bundle_o,
  output logic                       valid_o,
  input  logic                       rn_busy_i,
  output logic [$clog2(DEPTH):0]     occupancy_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  logic [BUNDLE_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]    wp;
  logic [PTR_W-1:0]    rp;
  logic [CNT_W-1:0]    cnt;
  logic                enq;
  logic                deq;

  // NOTE: both strobes depend only on registered state plus inputs, never on
  // each other, so a full queue cannot accept even when rename drains it.
  assign enq = bundle_vld_i & ~busy_o & ~flush_i & ~reset_i;
  assign deq = valid_o & ~rn_busy_i & ~flush_i & ~reset_i;

  assign busy_o      = (cnt == FULL);
  assign valid_o     = (cnt != '0);
  assign bundle_o    = mem[rp];
  assign occupancy_o = cnt;

  always_ff @(posedge cpu_clock_i) begin
    if (reset_i || flush_i) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (enq) wp <= wp + PTR_W'(1);
      if (deq) rp <= rp + PTR_W'(1);
      case ({enq, deq})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // NOTE: the payload array is deliberately not reset; valid_o qualifies it,
  // and leaving it reset-free lets it map onto plain flops or a register file.
  always_ff @(posedge cpu_clock_i) begin
    if (enq) mem[wp] <= bundle_i;
  end

endmodule
